// File: rtl/divfreq_scan.sv
`default_nettype none
// ============================================================================
// Module   : divfreq_scan
// Purpose  : Game-speed clock divider plus N-digit multiplexed BCD display
//            scanner.
//            - Speed divider: a programmable terminal-count counter that
//              produces a one-cycle `tick` and a toggling `CLK_div` level.
//              The period is staged through a shadow register and only
//              takes effect at a counter wrap, so an interval is never cut
//              short or stretched past its terminal count.
//            - Scanner: a free-running prescaler steps a digit index. Each
//              step drives one active-low digit common and that digit's BCD
//              code. Leading zeros can optionally be blanked.
// Ports    : CLK          system clock
//            RST_N        asynchronous active-low reset
//            en           speed divider run enable
//            period       new half-period terminal count
//            period_load  one-cycle strobe that captures `period`
//            CLK_div      divided clock level, toggles on every tick
//            tick         one-cycle pulse at each speed-counter wrap
//            digits_in    BCD digits, [3:0] is the least significant
//            bcd_out      BCD code of the selected digit, 4'hF when blanked
//            COM          active-low one-hot digit select
// Revision : 1.0 - initial release
// ============================================================================
module divfreq_scan #(
  parameter int CNT_W      = 25,
  parameter int PERIOD_RST = 25000000,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 25000,
  parameter int BLANK_LEAD = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  en,
  input  logic [CNT_W-1:0]      period,
  input  logic                  period_load,
  output logic                  CLK_div,
  output logic                  tick,
  input  logic [4*DIGITS-1:0]   digits_in,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     COM
);

  localparam int               SCAN_W      = $clog2(SCAN_DIV);
  localparam int               IDX_W       = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DIGITS - 1);

  // --------------------------------------------------------------------------
  // Speed divider
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] period_shadow;
  logic             shadow_pend;
  logic             div_q;
  logic             tick_q;
  logic             wrap;

  // ">=" rather than "==" keeps the counter bounded even if period_act were
  // ever below the running count.
  assign wrap = en && (count >= period_act);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count         <= '0;
      div_q         <= 1'b0;
      tick_q        <= 1'b0;
      period_act    <= PERIOD_INIT;
      period_shadow <= PERIOD_INIT;
      shadow_pend   <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (en) begin
        count <= wrap ? '0 : count + CNT_W'(1);
      end
      if (wrap) begin
        div_q <= ~div_q;
      end
      // The wrap uses the old period_act as its terminal count; a pending
      // shadow value becomes active for the next interval.
      if (wrap && shadow_pend) begin
        period_act <= period_shadow;
      end
      // A load coinciding with a wrap keeps the pending flag set, so the new
      // value lands one interval later.
      if (period_load) begin
        period_shadow <= period;
        shadow_pend   <= 1'b1;
      end else if (wrap) begin
        shadow_pend   <= 1'b0;
      end
    end
  end

  assign CLK_div = div_q;
  assign tick    = tick_q;

  // --------------------------------------------------------------------------
  // Digit scanner
  // --------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic [DIGITS-1:0] nz_above;
  logic              nz_acc;
  logic              blank;
  logic [3:0]        sel_digit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // nz_above[i] is set when digit i or any more significant digit is
  // non-zero; a digit with this bit clear is a leading zero.
  always_comb begin
    nz_acc   = 1'b0;
    nz_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_acc      = nz_acc | (|digits_in[4*i +: 4]);
      nz_above[i] = nz_acc;
    end
  end

  assign sel_digit = digits_in[4*idx +: 4];
  // Digit 0 is never blanked so an all-zero value still shows one "0".
  assign blank     = (BLANK_LEAD != 0) && (idx != '0) && !nz_above[idx];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      COM     <= '1;
      bcd_out <= 4'h0;
    end else if (blank) begin
      COM     <= '1;
      bcd_out <= 4'hF;
    end else begin
      COM     <= ~(DIGITS'(1) << idx);
      bcd_out <= sel_digit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divfreq_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_divfreq_scan
// Purpose  : Self-checking bench for divfreq_scan. Two instances share the
//            clock and divider controls: dut_a shows all digits, dut_b
//            blanks leading zeros. Expected tick edges and scan outputs are
//            queued when stimulus is applied and checked as the DUT responds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divfreq_scan;

  localparam int CNT_W = 8;
  localparam int DIGITS = 4;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              en = 1'b0;
  logic [CNT_W-1:0]  period = '0;
  logic              period_load = 1'b0;
  logic [15:0]       dig_a = '0;
  logic [15:0]       dig_b = '0;
  logic              div_a, tick_a, div_b, tick_b;
  logic [3:0]        bcd_a, bcd_b;
  logic [DIGITS-1:0] com_a, com_b;

  divfreq_scan #(.CNT_W(CNT_W), .PERIOD_RST(3), .DIGITS(DIGITS), .SCAN_DIV(4), .BLANK_LEAD(0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .en(en), .period(period), .period_load(period_load),
    .CLK_div(div_a), .tick(tick_a), .digits_in(dig_a), .bcd_out(bcd_a), .COM(com_a)
  );

  divfreq_scan #(.CNT_W(CNT_W), .PERIOD_RST(3), .DIGITS(DIGITS), .SCAN_DIV(4), .BLANK_LEAD(1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .en(en), .period(period), .period_load(period_load),
    .CLK_div(div_b), .tick(tick_b), .digits_in(dig_b), .bcd_out(bcd_b), .COM(com_b)
  );

  always #5 CLK = ~CLK;

  // Number of rising edges since reset was released.
  int cyc = 0;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int   edge_n;
    logic div;
  } tick_t;

  typedef struct {
    logic [3:0] ca, ba, cb, bb;
  } scan_t;

  tick_t tq[$];
  scan_t sq[$];
  tick_t mt;
  scan_t st;
  logic  exp_div = 1'b0;
  logic  mon_on = 1'b0;
  int    total = 0;
  int    bad = 0;

  // Tick scoreboard: every tick must match the head of the queue.
  always @(negedge CLK) begin
    if (RST_N && mon_on) begin
      if (tq.size() > 0 && tq[0].edge_n < cyc) begin
        total++; bad++;
        $display("FAIL missed_tick: no tick seen, required at edge %0d (now edge %0d)", tq[0].edge_n, cyc);
        void'(tq.pop_front());
      end
      if (tick_a === 1'b1) begin
        total++;
        if (tq.size() == 0 || tq[0].edge_n != cyc) begin
          bad++;
          $display("FAIL tick_time: tick at edge %0d, required edge %0d", cyc, (tq.size() > 0) ? tq[0].edge_n : -1);
        end else begin
          mt = tq.pop_front();
          total++;
          if (div_a !== mt.div) begin
            bad++;
            $display("FAIL clk_div_level: CLK_div=%b at edge %0d, required %b", div_a, cyc, mt.div);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic expect_tick(input int e);
    tick_t t;
    exp_div  = ~exp_div;
    t.edge_n = e;
    t.div    = exp_div;
    tq.push_back(t);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge CLK);
  endtask

  task automatic do_reset(input logic en_v);
    mon_on = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    period_load = 1'b0;
    en = en_v;
    tq.delete();
    sq.delete();
    exp_div = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    mon_on = 1'b1;
  endtask

  // Drive a one-cycle load so that it is captured on rising edge e.
  task automatic load_at(input int e, input logic [CNT_W-1:0] val);
    wait_edge(e - 1);
    period = val;
    period_load = 1'b1;
    @(negedge CLK);
    period_load = 1'b0;
  endtask

  function automatic void exp_scan(input logic [15:0] dg, input bit blank_lead, input int d,
                                   output logic [3:0] com, output logic [3:0] bcd);
    logic [3:0] one;
    logic       blanked;
    one     = 4'b0001;
    blanked = blank_lead && (d > 0) && ((dg >> (4 * d)) == 16'h0);
    com     = blanked ? 4'hF : ~(one << d);
    bcd     = blanked ? 4'hF : dg[4*d +: 4];
  endfunction

  task automatic test_reset();
    RST_N = 1'b0;
    en = 1'b1;
    @(negedge CLK);
    total++; if (com_a !== 4'hF) begin bad++; $display("FAIL rst_com_a: got %b want 1111", com_a); end
    total++; if (com_b !== 4'hF) begin bad++; $display("FAIL rst_com_b: got %b want 1111", com_b); end
    total++; if (bcd_a !== 4'h0) begin bad++; $display("FAIL rst_bcd_a: got %h want 0", bcd_a); end
    total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL rst_tick: got %b want 0", tick_a); end
    total++; if (div_a !== 1'b0) begin bad++; $display("FAIL rst_clk_div: got %b want 0", div_a); end
  endtask

  task automatic test_divider();
    do_reset(1'b1);
    for (int k = 1; k <= 4; k++) expect_tick(4 * k);
    wait_edge(18);
    total++; if (tq.size() != 0) begin bad++; $display("FAIL div_queue: %0d ticks outstanding, want 0", tq.size()); end
    total++; if (div_a !== exp_div) begin bad++; $display("FAIL div_final: CLK_div=%b want %b", div_a, exp_div); end
  endtask

  task automatic test_period_change();
    do_reset(1'b1);
    load_at(1, 8'd9);
    expect_tick(4); expect_tick(14); expect_tick(24);
    wait_edge(16);
    load_at(17, 8'd1);
    expect_tick(26); expect_tick(28); expect_tick(30);
    load_at(30, 8'd3);
    expect_tick(32); expect_tick(36); expect_tick(40);
    wait_edge(42);
    total++; if (tq.size() != 0) begin bad++; $display("FAIL period_queue: %0d ticks outstanding, want 0", tq.size()); end
    total++; if (div_a !== exp_div) begin bad++; $display("FAIL period_div: CLK_div=%b want %b", div_a, exp_div); end
  endtask

  task automatic test_enable();
    do_reset(1'b1);
    load_at(1, 8'd9);
    expect_tick(4);
    wait_edge(9);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL hold_tick: tick=%b at edge %0d want 0", tick_a, cyc); end
      total++; if (div_a !== exp_div) begin bad++; $display("FAIL hold_div: CLK_div=%b at edge %0d want %b", div_a, cyc, exp_div); end
    end
    en = 1'b1;
    expect_tick(34); expect_tick(44);
    wait_edge(46);
    total++; if (tq.size() != 0) begin bad++; $display("FAIL enable_queue: %0d ticks outstanding, want 0", tq.size()); end
  endtask

  task automatic test_scan();
    scan_t e;
    int    d;
    dig_a = 16'h1234;
    dig_b = 16'h0050;
    do_reset(1'b0);
    for (int k = 1; k <= 32; k++) begin
      if (k == 17) begin
        dig_a = 16'hA0B7;
        dig_b = 16'h0000;
      end
      d = ((k - 1) / 4) % 4;
      exp_scan(dig_a, 1'b0, d, e.ca, e.ba);
      exp_scan(dig_b, 1'b1, d, e.cb, e.bb);
      sq.push_back(e);
      @(negedge CLK);
      st = sq.pop_front();
      total++; if (com_a !== st.ca) begin bad++; $display("FAIL scan_com_a: edge %0d got %b want %b", cyc, com_a, st.ca); end
      total++; if (bcd_a !== st.ba) begin bad++; $display("FAIL scan_bcd_a: edge %0d got %h want %h", cyc, bcd_a, st.ba); end
      total++; if (com_b !== st.cb) begin bad++; $display("FAIL scan_com_b: edge %0d got %b want %b", cyc, com_b, st.cb); end
      total++; if (bcd_b !== st.bb) begin bad++; $display("FAIL scan_bcd_b: edge %0d got %h want %h", cyc, bcd_b, st.bb); end
    end
  endtask

  task automatic test_async_reset();
    dig_a = 16'h1234;
    do_reset(1'b1);
    expect_tick(4);
    // Load lands on the wrap edge, so it is still pending when reset hits.
    load_at(4, 8'd1);
    total++; if (tick_a !== 1'b1) begin bad++; $display("FAIL pre_rst_tick: got %b want 1", tick_a); end
    #2;
    RST_N = 1'b0;
    #1;
    total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL async_tick: got %b want 0", tick_a); end
    total++; if (div_a !== 1'b0) begin bad++; $display("FAIL async_clk_div: got %b want 0", div_a); end
    total++; if (com_a !== 4'hF) begin bad++; $display("FAIL async_com_a: got %b want 1111", com_a); end
    total++; if (com_b !== 4'hF) begin bad++; $display("FAIL async_com_b: got %b want 1111", com_b); end
    total++; if (bcd_a !== 4'h0) begin bad++; $display("FAIL async_bcd_a: got %h want 0", bcd_a); end
    mon_on = 1'b0;
    tq.delete();
    exp_div = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    mon_on = 1'b1;
    expect_tick(4); expect_tick(8); expect_tick(12);
    wait_edge(14);
    total++; if (tq.size() != 0) begin bad++; $display("FAIL async_queue: %0d ticks outstanding, want 0", tq.size()); end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_period_change();
    test_enable();
    test_scan();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
